// File: rtl/ct_piu_l2_csr_regs_if.sv
// CSR request/completion bus between the PIU CSR sync stage and the L2 CSR register file.
interface ct_piu_l2_csr_regs_if;
  localparam int unsigned OP_W   = 16;
  localparam int unsigned DATA_W = 64;

  logic              piu_regs_sel;
  logic [OP_W-1:0]   piu_regs_op;
  logic [DATA_W-1:0] piu_regs_wdata;
  logic              regs_piu_cmplt;
  logic [DATA_W-1:0] regs_piux_rdata;

  modport master (
    output piu_regs_sel, piu_regs_op, piu_regs_wdata,
    input  regs_piu_cmplt, regs_piux_rdata
  );

  modport slave (
    input  piu_regs_sel, piu_regs_op, piu_regs_wdata,
    output regs_piu_cmplt, regs_piux_rdata
  );
endinterface

// File: rtl/ct_piu_l2_csr_regs.sv
// L2 CSR register file: CSRRW/CSRRS/CSRRC access to CTRL, four 64-bit HPCP
// counters and sticky overflow status, plus the counter overflow interrupts.
module ct_piu_l2_csr_regs (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  ct_piu_l2_csr_regs_if.slave  bus,
  input  logic [3:0]           piu_regs_hpcp_cnt_en,
  input  logic [3:0]           l2_hpcp_evt,
  output logic [3:0]           regs_piu_hpcp_l2of_int,
  output logic [31:0]          regs_l2_ctrl
);
  localparam int unsigned NUM_CNT = 4;
  localparam int unsigned DW      = 64;
  localparam int unsigned CTRL_W  = 32;
  localparam int unsigned SEL_W   = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_CMPLT} state_t;

  state_t              r_state;
  logic                r_cmplt;
  logic [DW-1:0]       r_rdata;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [DW-1:0]       r_cnt [NUM_CNT];
  logic [NUM_CNT-1:0]  r_status;
  logic [NUM_CNT-1:0]  r_int;

  logic [SEL_W-1:0]    w_sel;
  logic                w_sel_ok;
  logic                w_op_ok;
  logic [SEL_W-1:0]    w_we;
  logic [DW-1:0]       w_old;
  logic [DW-1:0]       w_new;
  logic [NUM_CNT-1:0]  w_cnt_hit;
  logic [NUM_CNT-1:0]  w_wrap;
  logic [NUM_CNT-1:0]  w_status_nxt;
  logic                w_unused;

  assign w_sel    = bus.piu_regs_op[11:4];
  assign w_sel_ok = $onehot(w_sel);
  assign w_op_ok  = bus.piu_regs_op[3] && $onehot(bus.piu_regs_op[2:0]);
  assign w_we     = (r_state == ST_ACC && w_sel_ok && w_op_ok) ? w_sel : '0;
  assign w_unused = ^bus.piu_regs_op[15:12];

  // Old-value read mux; reserved and malformed selects read zero.
  always_comb begin
    w_old = '0;
    case (w_sel)
      8'h01:   w_old = {32'h0, r_ctrl};
      8'h02:   w_old = r_cnt[0];
      8'h04:   w_old = r_cnt[1];
      8'h08:   w_old = r_cnt[2];
      8'h10:   w_old = r_cnt[3];
      8'h20:   w_old = {60'h0, r_status};
      default: w_old = '0;
    endcase
  end

  always_comb begin
    w_new = w_old;
    if (bus.piu_regs_op[2])      w_new = bus.piu_regs_wdata;
    else if (bus.piu_regs_op[1]) w_new = w_old | bus.piu_regs_wdata;
    else if (bus.piu_regs_op[0]) w_new = w_old & ~bus.piu_regs_wdata;
  end

  // A CSR write to a counter drops that cycle's increment, and with it any wrap.
  always_comb begin
    w_cnt_hit = piu_regs_hpcp_cnt_en & l2_hpcp_evt;
    w_wrap    = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      w_wrap[i] = w_cnt_hit[i] & (&r_cnt[i]) & ~w_we[i+1];
    end
    w_status_nxt = (w_we[5] ? w_new[NUM_CNT-1:0] : r_status) | w_wrap;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= ST_IDLE;
      r_cmplt <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.piu_regs_sel) r_state <= ST_ACC;
        end
        ST_ACC: begin
          r_rdata <= w_old;
          r_cmplt <= 1'b1;
          r_state <= ST_CMPLT;
        end
        ST_CMPLT: begin
          r_rdata <= '0;
          r_cmplt <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_rdata <= '0;
          r_cmplt <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_ctrl   <= '0;
      r_status <= '0;
      r_int    <= '0;
      for (int unsigned i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
    end else begin
      if (w_we[0]) r_ctrl <= w_new[CTRL_W-1:0];
      r_status <= w_status_nxt;
      r_int    <= r_status;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if (w_we[i+1])        r_cnt[i] <= w_new;
        else if (w_cnt_hit[i]) r_cnt[i] <= r_cnt[i] + 64'd1;
      end
    end
  end

  assign bus.regs_piu_cmplt     = r_cmplt;
  assign bus.regs_piux_rdata    = r_rdata;
  assign regs_piu_hpcp_l2of_int = r_int;
  assign regs_l2_ctrl           = r_ctrl;
endmodule

// File: doc/ct_piu_l2_csr_regs.md
# ct_piu_l2_csr_regs

L2 CSR register file and L2 hardware performance counters in the PIU. Consumes the registered CSR request (`piu_regs_sel`/`op`/`wdata`) from the PIU CSR sync stage and executes a CSRRW/CSRRS/CSRRC read-modify-write on the addressed register. It returns a one-cycle completion with the pre-write value (`regs_piu_cmplt`/`regs_piux_rdata`). It also runs four 64-bit event counters and raises sticky overflow interrupts.

## Interface
Parameters: none.

- `forever_cpuclk` — in, 1: clock.
- `cpurst_b` — in, 1: reset; asynchronous, active-low.
- `piu_regs_sel` — in, 1: CSR request valid; held high by upstream through the completion cycle; low the cycle after.
- `piu_regs_op` — in, 16: `[15]` DCA (always 0 here, ignored), `[14:12]` unused, `[11:4]` REG7..REG0 one-hot select, `[3]` WT write enable, `[2]` CSRRW, `[1]` CSRRS, `[0]` CSRRC.
- `piu_regs_wdata` — in, 64: write/mask operand.
- `piu_regs_hpcp_cnt_en` — in, 4: per-counter count enable.
- `l2_hpcp_evt` — in, 4: per-counter event pulse; 1 increment per cycle high.
- `regs_piu_cmplt` — out, 1: completion pulse (registered).
- `regs_piux_rdata` — out, 64: old register value; valid with cmplt, 0 otherwise (registered).
- `regs_piu_hpcp_l2of_int` — out, 4: overflow interrupt per counter (registered).
- `regs_l2_ctrl` — out, 32: L2 control register contents.

## Operation
Register map (select = `op[11:4]`):
- REG0: CTRL; bits `[31:0]` RW, `[63:32]` read 0.
- REG1..REG4: HPCP counters 0..3; 64-bit RW.
- REG5: overflow status `[3:0]`; RW, sticky; `[63:4]` read 0.
- REG6, REG7: reserved; read 0, writes ignored, still complete.
- Select with zero bits or more than one bit set: read 0, no write, still complete.

FSM states IDLE, ACC, CMPLT:
- IDLE: `piu_regs_sel`=1 → ACC. Otherwise stay.
- ACC (1 cycle): read old value; compute new value; perform the write at the end of the cycle; latch old value into rdata → CMPLT.
- CMPLT: `regs_piu_cmplt`=1 for exactly one cycle; `regs_piux_rdata`=old value → IDLE unconditionally.

Write rules (only when WT=1):
- CSRRW: new = wdata.
- CSRRS: new = old | wdata.
- CSRRC: new = old & ~wdata.
- WT=0, or not exactly one of `op[2:0]` set: no write; the read still completes.

Counters:
- Counter i increments by 1 in any cycle with `cnt_en[i] & evt[i]`.
- A CSR write to counter i in the same cycle wins; that increment is dropped.
- Increment from 64'hFFFF_FFFF_FFFF_FFFF wraps to 0 and sets `status[i]`.
- `regs_piu_hpcp_l2of_int[i]` = `status[i]`, delayed one cycle (registered).
- A status write that clears bit i in the same cycle a wrap sets bit i: set wins.

Counting continues in all FSM states.

## Timing
- Reset values: FSM IDLE; `regs_piu_cmplt`=0; `regs_piux_rdata`=0; `regs_piu_hpcp_l2of_int`=0; `regs_l2_ctrl`=0; counters 0; status 0.
- `piu_regs_sel` first high in cycle N: ACC in N+1, `regs_piu_cmplt`=1 in N+2.
- `piu_regs_sel` remains high through N+2; the FSM must not re-accept it in CMPLT. Back-to-back requests are ≥3 cycles apart.
- Write becomes visible (registers, `regs_l2_ctrl`) in N+2.
- Read value is the register state sampled during ACC (N+1), including any increment committed at the end of cycle N.
- Wrap at end of cycle M: `status` set in M+1; interrupt high in M+2.
- Reset asserted mid-request: all state returns to reset values immediately; no completion is issued for the aborted request.

## Test plan
- Reset → all outputs 0. CSRRW REG0 wdata=0x1234_5678_9ABC_DEF0, WT=1 → cmplt 2 cycles after sel, rdata=0; next read of REG0 returns 0x9ABC_DEF0; `regs_l2_ctrl`=0x9ABC_DEF0.
- CTRL=0xF0; CSRRS 0x0F → rdata=0xF0, CTRL=0xFF. Then CSRRC 0x3C → rdata=0xFF, CTRL=0xC3. Then CSRRS with WT=0 → rdata=0xC3, CTRL unchanged.
- Write counter1=0xFFFF_FFFF_FFFF_FFFE; cnt_en[1]=1, evt[1] high 2 cycles → counter1=0; `status[1]`=1; `hpcp_l2of_int[1]`=1 two cycles after the wrap. CSRRC REG5 0x2 → int drops.
- Counter0 counting every cycle; CSRRW counter0=0x100 → rdata=old count; counter0 reads 0x100 + cycles elapsed since write.
- REG6 write, and a select with op[11:4]=0x03 → rdata=0, no register changes, cmplt exactly once each; `sel` held high through cmplt produces no second cmplt.
- Assert `cpurst_b` low during ACC → no cmplt; all registers 0; the next request completes normally.
